// File: rtl/control_cajero_transaccion.sv
// ATM transaction sequencer: PIN entry and compare, attempt tracking with warning/lockout,
// and a single deposit or withdrawal against the internal balance register.
module control_cajero_transaccion #(
  parameter logic [31:0] BALANCE_INICIAL = 32'd1000,
  parameter int          INTENTOS_MAX    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tarjeta_recibida,
  input  logic        tipo_trans,
  input  logic        digito_stb,
  input  logic [3:0]  digito,
  input  logic [15:0] pin,
  input  logic        monto_stb,
  input  logic [31:0] monto,
  output logic [31:0] balance_actualizado,
  output logic        balance_stb,
  output logic        entregar_dinero,
  output logic        pin_incorrecto,
  output logic        advertencia,
  output logic        bloqueo,
  output logic        fondos_insuficientes
);

  localparam int IW = $clog2(INTENTOS_MAX + 1);
  localparam logic [IW-1:0] INT_AVISO  = IW'(INTENTOS_MAX - 1);
  localparam logic [IW-1:0] INT_LIMITE = IW'(INTENTOS_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RECIBIR_PIN,
    COMPARAR,
    BLOQUEADO,
    ESPERA_MONTO,
    EJECUTAR,
    FIN
  } estado_t;

  estado_t       estado_reg, estado_next;
  logic [IW-1:0] intentos_reg, intentos_next;
  logic [1:0]    cuenta_reg, cuenta_next;
  logic [15:0]   pin_shift_reg, pin_shift_next;
  logic [31:0]   monto_reg, monto_next;
  logic          tipo_reg, tipo_next;
  logic [31:0]   balance_reg, balance_next;
  logic          balance_stb_reg, balance_stb_next;
  logic          entregar_reg, entregar_next;
  logic          pin_inc_reg, pin_inc_next;
  logic          adv_reg, adv_next;
  logic          bloqueo_reg, bloqueo_next;
  logic          fondos_reg, fondos_next;

  logic [32:0]   suma_deposito;
  logic [IW-1:0] intentos_inc;

  // Deposit sum carries into bit 32 so overflow can be saturated.
  assign suma_deposito = {1'b0, balance_reg} + {1'b0, monto_reg};
  assign intentos_inc  = intentos_reg + IW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg      <= IDLE;
      intentos_reg    <= '0;
      cuenta_reg      <= '0;
      pin_shift_reg   <= '0;
      monto_reg       <= '0;
      tipo_reg        <= 1'b0;
      balance_reg     <= BALANCE_INICIAL;
      balance_stb_reg <= 1'b0;
      entregar_reg    <= 1'b0;
      pin_inc_reg     <= 1'b0;
      adv_reg         <= 1'b0;
      bloqueo_reg     <= 1'b0;
      fondos_reg      <= 1'b0;
    end else begin
      estado_reg      <= estado_next;
      intentos_reg    <= intentos_next;
      cuenta_reg      <= cuenta_next;
      pin_shift_reg   <= pin_shift_next;
      monto_reg       <= monto_next;
      tipo_reg        <= tipo_next;
      balance_reg     <= balance_next;
      balance_stb_reg <= balance_stb_next;
      entregar_reg    <= entregar_next;
      pin_inc_reg     <= pin_inc_next;
      adv_reg         <= adv_next;
      bloqueo_reg     <= bloqueo_next;
      fondos_reg      <= fondos_next;
    end
  end

  always_comb begin
    estado_next      = estado_reg;
    intentos_next    = intentos_reg;
    cuenta_next      = cuenta_reg;
    pin_shift_next   = pin_shift_reg;
    monto_next       = monto_reg;
    tipo_next        = tipo_reg;
    balance_next     = balance_reg;
    adv_next         = adv_reg;
    bloqueo_next     = bloqueo_reg;
    balance_stb_next = 1'b0;
    entregar_next    = 1'b0;
    pin_inc_next     = 1'b0;
    fondos_next      = 1'b0;

    case (estado_reg)
      IDLE: begin
        if (tarjeta_recibida) begin
          estado_next    = RECIBIR_PIN;
          cuenta_next    = '0;
          pin_shift_next = '0;
        end
      end

      RECIBIR_PIN: begin
        // Card removal beats a coincident digit strobe; attempts are kept.
        if (!tarjeta_recibida) begin
          estado_next    = IDLE;
          cuenta_next    = '0;
          pin_shift_next = '0;
        end else if (digito_stb) begin
          pin_shift_next = {pin_shift_reg[11:0], digito};
          cuenta_next    = cuenta_reg + 2'd1;
          if (cuenta_reg == 2'd3) begin
            estado_next = COMPARAR;
          end
        end
      end

      COMPARAR: begin
        cuenta_next    = '0;
        pin_shift_next = '0;
        if (pin_shift_reg == pin) begin
          intentos_next = '0;
          adv_next      = 1'b0;
          estado_next   = tarjeta_recibida ? ESPERA_MONTO : IDLE;
        end else begin
          intentos_next = intentos_inc;
          pin_inc_next  = 1'b1;
          adv_next      = (intentos_inc == INT_AVISO);
          if (intentos_inc == INT_LIMITE) begin
            bloqueo_next = 1'b1;
            estado_next  = BLOQUEADO;
          end else begin
            estado_next = tarjeta_recibida ? RECIBIR_PIN : IDLE;
          end
        end
      end

      BLOQUEADO: begin
        estado_next = BLOQUEADO;
      end

      ESPERA_MONTO: begin
        if (!tarjeta_recibida) begin
          estado_next = IDLE;
        end else if (monto_stb) begin
          monto_next  = monto;
          tipo_next   = tipo_trans;
          estado_next = EJECUTAR;
        end
      end

      EJECUTAR: begin
        balance_stb_next = 1'b1;
        if (!tipo_reg) begin
          balance_next = suma_deposito[32] ? 32'hFFFF_FFFF : suma_deposito[31:0];
        end else if (monto_reg <= balance_reg) begin
          balance_next  = balance_reg - monto_reg;
          entregar_next = 1'b1;
        end else begin
          fondos_next = 1'b1;
        end
        estado_next = tarjeta_recibida ? FIN : IDLE;
      end

      FIN: begin
        if (!tarjeta_recibida) begin
          estado_next = IDLE;
        end
      end

      default: begin
        estado_next = IDLE;
      end
    endcase
  end

  assign balance_actualizado  = balance_reg;
  assign balance_stb          = balance_stb_reg;
  assign entregar_dinero      = entregar_reg;
  assign pin_incorrecto       = pin_inc_reg;
  assign advertencia          = adv_reg;
  assign bloqueo              = bloqueo_reg;
  assign fondos_insuficientes = fondos_reg;

endmodule
